// File: rtl/spram_arbiter.sv
// Two-port request/grant arbiter and STANDBY power sequencer for one SB_SPRAM256KA (16K x 16).
// Define SPRAM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise port 0 has fixed priority.
module spram_arbiter #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 14,
  parameter int unsigned IDLE_TIMEOUT      = 64,
  parameter int unsigned WAKE_CYCLES       = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr1,
  input  logic [15:0]                  wdata0,
  input  logic [15:0]                  wdata1,
  output logic                         gnt0,
  output logic                         gnt1,
  output logic                         rvalid0,
  output logic                         rvalid1,
  output logic [15:0]                  rdata,
  output logic                         standby
);

  localparam int unsigned IdleW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int unsigned WakeW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(IDLE_TIMEOUT);
  localparam logic [WakeW-1:0] WakeLast = WakeW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StActive, StStandby, StWake} state_e;

  state_e           state_q, state_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [WakeW-1:0] wake_q, wake_d;
  logic             win0, win1;
  logic             gnt0_c, gnt1_c;
  logic             rvalid0_q, rvalid1_q;

  logic        ram_cs, ram_wren, ram_standby;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;

`ifdef SPRAM_ARB_ROUND_ROBIN_EN
  // prio_q = 1 favours port 1, i.e. port 0 was granted most recently.
  logic prio_q, prio_d;

  assign win0 = req0 & (~req1 | ~prio_q);

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end
`else
  assign win0 = req0;
`endif

  assign win1 = req1 & ~win0;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    case (state_q)
      StActive: begin
        gnt0_c = win0;
        gnt1_c = win1;
        if (req0 || req1) begin
          idle_d = '0;
        end else begin
          if (idle_q != IdleMax) idle_d = idle_q + IdleW'(1);
          if (IDLE_TIMEOUT != 0 && idle_d == IdleMax) state_d = StStandby;
        end
      end
      StStandby: begin
        if (req0 || req1) begin
          state_d = StWake;
          wake_d  = '0;
        end
      end
      StWake: begin
        idle_d = '0;
        if (wake_q == WakeLast) begin
          state_d = StActive;
          wake_d  = '0;
        end else begin
          wake_d = wake_q + WakeW'(1);
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StActive;
      idle_q    <= '0;
      wake_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      wake_q    <= wake_d;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
    end
  end

  // Grants are combinational from req, so they are gated by reset directly.
  assign gnt0        = gnt0_c & rst;
  assign gnt1        = gnt1_c & rst;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign standby     = (state_q == StStandby);
  assign ram_standby = standby;
  assign ram_cs      = gnt0 | gnt1;
  assign ram_wren    = gnt1 ? we1 : we0;
  assign ram_wdata   = gnt1 ? wdata1 : wdata0;

  always_comb begin
    ram_addr = '0;
    ram_addr[ADDRESS_BUS_WIDTH-1:0] = gnt1 ? addr1 : addr0;
  end

`ifdef SYNTHESIS
  SB_SPRAM256KA u_spram (
    .ADDRESS   (ram_addr),
    .DATAIN    (ram_wdata),
    .MASKWREN  (4'b1111),
    .WREN      (ram_wren),
    .CHIPSELECT(ram_cs),
    .CLOCK     (clk),
    .STANDBY   (ram_standby),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (rdata)
  );
`else
  // Behavioural stand-in for the primitive: registered read, full-word write.
  logic [15:0] mem [16384];
  logic [15:0] ram_rdata_q;

  always_ff @(posedge clk) begin
    if (ram_cs && !ram_standby) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      else          ram_rdata_q   <= mem[ram_addr];
    end
  end

  assign rdata = ram_rdata_q;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: vector table plus hand-written idle, wake and reset sequences.
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [13:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, standby;
  logic [15:0] rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spram_arbiter #(
    .ADDRESS_BUS_WIDTH(14),
    .IDLE_TIMEOUT     (4),
    .WAKE_CYCLES      (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .rdata  (rdata),
    .standby(standby)
  );

  typedef struct {
    logic        r0, w0;
    logic [13:0] a0;
    logic [15:0] d0;
    logic        r1, w1;
    logic [13:0] a1;
    logic [15:0] d1;
    logic        g0, g1, v0, v1;
    logic [15:0] rd;
    logic        sb;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [13:0] a0, logic [15:0] d0,
                              logic r1, logic w1, logic [13:0] a1, logic [15:0] d1,
                              logic g0, logic g1, logic v0, logic v1, logic [15:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd; v.sb = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [13:0] a, input logic [15:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [13:0] a, input logic [15:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  vec_t tbl [13];

  initial begin
    tbl[0]  = mk(1, 1, 14'h0010, 16'hBEEF, 0, 0, 14'h0, 16'h0,       1, 0, 0, 0, 16'h0);
    tbl[1]  = mk(0, 0, 14'h0,    16'h0,    1, 0, 14'h0010, 16'h0,   0, 1, 0, 0, 16'h0);
    tbl[2]  = mk(0, 0, 14'h0,    16'h0,    0, 0, 14'h0, 16'h0,      0, 0, 0, 1, 16'hBEEF);
    tbl[3]  = mk(1, 1, 14'h3FFF, 16'h1234, 0, 0, 14'h0, 16'h0,      1, 0, 0, 0, 16'h0);
    tbl[4]  = mk(0, 0, 14'h0,    16'h0,    1, 1, 14'h0000, 16'h5678, 0, 1, 0, 0, 16'h0);
    tbl[5]  = mk(1, 0, 14'h3FFF, 16'h0,    0, 0, 14'h0, 16'h0,      1, 0, 0, 0, 16'h0);
    tbl[6]  = mk(0, 0, 14'h0,    16'h0,    1, 0, 14'h0000, 16'h0,   0, 1, 1, 0, 16'h1234);
    tbl[7]  = mk(0, 0, 14'h0,    16'h0,    0, 0, 14'h0, 16'h0,      0, 0, 0, 1, 16'h5678);
`ifdef SPRAM_ARB_ROUND_ROBIN_EN
    tbl[8]  = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 1, 0, 0, 0, 16'h0);
    tbl[9]  = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 0, 1, 1, 0, 16'hBEEF);
    tbl[10] = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 1, 0, 0, 1, 16'h1234);
    tbl[11] = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 0, 1, 1, 0, 16'hBEEF);
    tbl[12] = mk(0, 0, 14'h0,    16'h0, 0, 0, 14'h0,    16'h0, 0, 0, 0, 1, 16'h1234);
`else
    tbl[8]  = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 1, 0, 0, 0, 16'h0);
    tbl[9]  = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 1, 0, 1, 0, 16'hBEEF);
    tbl[10] = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 1, 0, 1, 0, 16'hBEEF);
    tbl[11] = mk(1, 0, 14'h0010, 16'h0, 1, 0, 14'h3FFF, 16'h0, 1, 0, 1, 0, 16'hBEEF);
    tbl[12] = mk(0, 0, 14'h0,    16'h0, 0, 0, 14'h0,    16'h0, 0, 0, 1, 0, 16'hBEEF);
`endif

    // Reset state, with a request held to show grants are suppressed.
    rst = 1'b0;
    set0(1, 0, 14'h0, 16'h0);
    set1(0, 0, 14'h0, 16'h0);
    @(negedge clk);
    chk("rst_gnt0", {15'b0, gnt0}, 16'h0);
    chk("rst_gnt1", {15'b0, gnt1}, 16'h0);
    chk("rst_rvalid0", {15'b0, rvalid0}, 16'h0);
    chk("rst_rvalid1", {15'b0, rvalid1}, 16'h0);
    chk("rst_standby", {15'b0, standby}, 16'h0);
    cyc();
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set0(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      set1(tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d_gnt0", i), {15'b0, gnt0}, {15'b0, tbl[i].g0});
      chk($sformatf("vec%0d_gnt1", i), {15'b0, gnt1}, {15'b0, tbl[i].g1});
      chk($sformatf("vec%0d_rvalid0", i), {15'b0, rvalid0}, {15'b0, tbl[i].v0});
      chk($sformatf("vec%0d_rvalid1", i), {15'b0, rvalid1}, {15'b0, tbl[i].v1});
      chk($sformatf("vec%0d_standby", i), {15'b0, standby}, {15'b0, tbl[i].sb});
      if (tbl[i].v0 || tbl[i].v1) chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].rd);
      cyc();
    end

    // Idle timeout: last request in vec11 (cycle N); STANDBY from N+5. Now at N+2.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_standby", k), {15'b0, standby}, 16'h0);
      cyc();
    end
    @(negedge clk);
    chk("enter_standby", {15'b0, standby}, 16'h1);
    cyc();

    // Wake: req in cycle M, WAKE for M+1..M+3, grant in M+4.
    set0(1, 0, 14'h0010, 16'h0);
    @(negedge clk);
    chk("wake_req_standby", {15'b0, standby}, 16'h1);
    chk("wake_req_gnt0", {15'b0, gnt0}, 16'h0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wake%0d_standby", k), {15'b0, standby}, 16'h0);
      chk($sformatf("wake%0d_gnt0", k), {15'b0, gnt0}, 16'h0);
      cyc();
    end
    @(negedge clk);
    chk("wake_done_gnt0", {15'b0, gnt0}, 16'h1);
    cyc();
    set0(0, 0, 14'h0, 16'h0);
    @(negedge clk);
    chk("wake_rvalid0", {15'b0, rvalid0}, 16'h1);
    chk("wake_rdata", rdata, 16'hBEEF);
    cyc();

    // Request exactly when the idle count reaches the timeout (3 idle cycles already seen here+2).
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("edge_idle%0d_standby", k), {15'b0, standby}, 16'h0);
      cyc();
    end
    set1(1, 1, 14'h0001, 16'hA5A5);
    @(negedge clk);
    chk("edge_gnt1", {15'b0, gnt1}, 16'h1);
    cyc();
    set1(0, 0, 14'h0, 16'h0);
    @(negedge clk);
    chk("edge_no_standby", {15'b0, standby}, 16'h0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("edge2_idle%0d_standby", k), {15'b0, standby}, 16'h0);
      cyc();
    end
    @(negedge clk);
    chk("edge2_standby", {15'b0, standby}, 16'h1);
    cyc();

    // Wake via a port-1 read, then reset the cycle after its grant.
    set1(1, 0, 14'h0001, 16'h0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wake1_%0d_gnt1", k), {15'b0, gnt1}, 16'h0);
      cyc();
    end
    @(negedge clk);
    chk("wake1_gnt1", {15'b0, gnt1}, 16'h1);
    cyc();
    rst = 1'b0;
    set0(1, 0, 14'h0010, 16'h0);
    @(negedge clk);
    chk("midrst_rvalid1", {15'b0, rvalid1}, 16'h0);
    chk("midrst_gnt0", {15'b0, gnt0}, 16'h0);
    chk("midrst_standby", {15'b0, standby}, 16'h0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt0", {15'b0, gnt0}, 16'h1);
    chk("post_rst_gnt1", {15'b0, gnt1}, 16'h0);
    chk("post_rst_rvalid1", {15'b0, rvalid1}, 16'h0);
    cyc();
    set0(0, 0, 14'h0, 16'h0);
    @(negedge clk);
    chk("reissue_gnt1", {15'b0, gnt1}, 16'h1);
    chk("reissue_rvalid0", {15'b0, rvalid0}, 16'h1);
    chk("reissue_rdata0", rdata, 16'hBEEF);
    cyc();
    set1(0, 0, 14'h0, 16'h0);
    @(negedge clk);
    chk("reissue_rvalid1", {15'b0, rvalid1}, 16'h1);
    chk("reissue_rdata1", rdata, 16'hA5A5);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port arbiter and power sequencer for one iCE40 SB_SPRAM256KA (16K x 16). Two independent requesters, e.g. a producer writing frame data and a consumer reading it back, share the single-port SPRAM through a request/grant handshake. At most one access is issued per cycle. The block also drops the RAM into STANDBY after a programmable idle period and wakes it on demand. The SPRAM primitive is instantiated inside this block.

## Interface
Parameters:
- ADDRESS_BUS_WIDTH, 14, address width; values below 14 zero-extend onto the SPRAM ADDRESS pins.
- IDLE_TIMEOUT, 64, consecutive idle ACTIVE cycles before entering STANDBY; 0 disables power-down.
- WAKE_CYCLES, 3, cycles spent in WAKE before grants resume; minimum 1.

Ports:
- clk  in  1  single clock; all logic and the SPRAM run on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; held with req.
- addr0 / addr1  in  ADDRESS_BUS_WIDTH  word address; held with req.
- wdata0 / wdata1  in  16  write data; held with req.
- gnt0 / gnt1  out  1  single-cycle grant; the access is performed in this cycle.
- rvalid0 / rvalid1  out  1  read data valid pulse for that port.
- rdata  out  16  SPRAM DATAOUT, shared; meaningful only while rvalid0 or rvalid1 is high.
- standby  out  1  high while the SPRAM STANDBY pin is asserted.

## Operation
- FSM states are ACTIVE, STANDBY and WAKE. The reset state is ACTIVE.
- ACTIVE:
  - Each cycle the arbiter selects at most one requester.
  - gnt is combinational from req, state and priority.
  - The SPRAM pins are driven combinationally from the granted port: CHIPSELECT = 1, WREN = we, ADDRESS = addr, DATAIN = wdata, MASKWREN = 4'b1111.
  - With no grant, CHIPSELECT = 0.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port with priority is granted. The other port keeps req high and is served on a later cycle.
  - The priority pointer always favours the port not granted most recently. Reset favours port 0.
- Read completion: a read granted in cycle N produces rvalid for the same port in cycle N+1, with rdata valid in that cycle. Writes produce no rvalid.
- Idle counter:
  - Counts consecutive ACTIVE cycles with req0 = req1 = 0.
  - Clears to 0 on any request.
  - When the count reaches IDLE_TIMEOUT, the next state is STANDBY.
  - The counter saturates and does not wrap.
- STANDBY:
  - STANDBY pin = 1, standby = 1, CHIPSELECT = 0, no grants.
  - Any req moves the FSM to WAKE on the next edge.
- WAKE:
  - STANDBY pin = 0, standby = 0, no grants.
  - Counts WAKE_CYCLES cycles, then returns to ACTIVE.
  - Requests stay pending throughout and are arbitrated normally in the first ACTIVE cycle.
- SLEEP = 0 and POWEROFF = 1 (powered) at all times.
- Reset asserted mid-operation:
  - The FSM returns to ACTIVE, the counters clear and the pointer returns to port 0.
  - A pending rvalid is dropped. A read granted in the cycle before reset is lost and must be re-issued.
  - A write granted in the cycle before reset has already been clocked into the SPRAM at that edge.

## Timing
- Reset values: gnt0 = gnt1 = 0 while rst is low, rvalid0 = rvalid1 = 0, standby = 0, state = ACTIVE, idle count = 0, wake count = 0, pointer = port 0. rdata is undefined.
- Grant latency from an idle ACTIVE state: 0 cycles (same cycle as req).
- Read latency: 1 cycle from grant to rvalid.
- Throughput: 1 access per cycle. Under continuous contention the ports alternate every cycle.
- STANDBY entry: with last request in cycle N, the FSM is in STANDBY from cycle N+IDLE_TIMEOUT+1. Any read has completed before entry.
- Wake from STANDBY: req in cycle M gives WAKE in cycles M+1 .. M+WAKE_CYCLES, and the first grant is possible in cycle M+WAKE_CYCLES+1.
- A request arriving in the same cycle the count reaches IDLE_TIMEOUT takes precedence: the FSM stays ACTIVE and the request is granted.

## Configuration
- SPRAM_ARB_ROUND_ROBIN_EN defined: round-robin priority as described in Operation.
- SPRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins conflicts. There is no priority pointer, and port 1 can starve under continuous port 0 traffic.

## Test plan
- Write 0xBEEF to address 0x0010 via port 0, then read it via port 1 -> gnt0 pulses in the write cycle; gnt1 pulses in the read cycle; rvalid1 = 1 and rdata = 0xBEEF one cycle later.
- Both ports hold read requests for 4 cycles, round-robin build -> grant order 0, 1, 0, 1. Fixed-priority build -> gnt0 on all 4 cycles, gnt1 never.
- IDLE_TIMEOUT = 4, no requests after reset -> standby rises in cycle 5. A req0 read then gives 3 WAKE cycles with gnt0 = 0, followed by gnt0.
- A request in exactly the cycle the idle count hits the timeout -> no STANDBY entry and gnt issued the same cycle.
- rst pulled low the cycle after a port-1 read grant -> rvalid1 stays 0, the FSM is in ACTIVE, and the pointer favours port 0 after release.
- Write to address 0x3FFF, then read to address 0x0000 -> no aliasing: each location returns its own data.
